variance_unit: RTL and testbench
================================

// Module: variance_unit
// PURPOSE
//  Computes the population variance of one D_MODEL-element vector around a supplied mean.
//  LayerNorm datapath stage: consumes the vector and the mean-unit result, feeds the rsqrt/normalize stage.
//  Processes NUM_PE elements per cycle; start/busy/valid handshake.
// PARAMETERS
//  D_MODEL         128  vector length; power of two, multiple of NUM_PE
//  DATA_WIDTH      24   width of elements, mean and result
//  NUM_PE          8    parallel subtract/square lanes (elements per cycle)
//  INTERNAL_WIDTH  48   width of each squared term; must be >= 2*DATA_WIDTH
// PORTS
//  clk             in   1                   clock, rising edge
//  rst             in   1                   synchronous, active-high reset
//  data_in_flat    in   D_MODEL*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH], signed 2's complement
//  mean_in         in   DATA_WIDTH          signed mean of the vector
//  start_variance  in   1                   start request; sampled only in IDLE
//  variance_out    out  DATA_WIDTH          unsigned variance result
//  variance_valid  out  1                   one-cycle pulse: variance_out updated
//  busy            out  1                   high while a computation is in progress
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; variance_out=0, variance_valid=0, busy=0; accumulator and counter cleared.
//    Reset mid-operation aborts; no valid pulse is produced for the aborted job.
//  - FSM IDLE -> ACCUM -> DONE -> IDLE.
//  - IDLE: on posedge with start_variance=1, latch data_in_flat and mean_in, clear acc and chunk counter,
//    go to ACCUM, busy=1 from that edge. Inputs may change after the start edge.
//  - ACCUM: each cycle process chunk c (elements c*NUM_PE .. c*NUM_PE+NUM_PE-1):
//    d = x - mean computed at DATA_WIDTH+1 bits, clamped to signed DATA_WIDTH range;
//    sq = d*d (unsigned, INTERNAL_WIDTH bits); acc += sum of the NUM_PE squares.
//    acc width INTERNAL_WIDTH+$clog2(D_MODEL); no overflow possible.
//    After D_MODEL/NUM_PE cycles (16 at defaults) go to DONE.
//  - DONE (one cycle): v = acc >> $clog2(D_MODEL) (truncating divide); variance_out = v, saturated to
//    2^DATA_WIDTH-1 if larger; variance_valid=1 for exactly this cycle; busy=0; next state IDLE.
//  - Latency: start edge E0 -> variance_valid high after edge E0+D_MODEL/NUM_PE+1 (E17 at defaults).
//    busy high for edges E0..E16.
//  - variance_out holds its value between completions.
//  - start_variance while busy or in DONE is ignored (not queued).
//  - start_variance held high: a new job starts on the first IDLE edge after DONE.
// TESTING
//  1. All 128 elements = 100, mean_in = 100 -> variance_valid pulse, variance_out = 0; busy was seen high before valid.
//  2. Elements alternate 99/101, mean_in = 100 -> variance_out = 1.
//  3. x[i] = i (i=0..127), mean_in = 63 -> sum 174784 >> 7 = variance_out 1365.
//  4. All elements = -5 (0xFFFFFB), mean_in = 3 -> variance_out = 64 (signed handling).
//  5. Elements alternate 0x7FFFFF/0x800000, mean_in = 0 -> result 2^46 saturates to variance_out = 0xFFFFFF.
//  6. Protocol: a second start pulse mid-job is ignored (one valid only, after 17 cycles); rst asserted
//     mid-job -> busy=0, outputs 0, no valid; a fresh start after reset completes correctly.

Source files
------------

// File: rtl/variance_unit.sv
// Population variance of one D_MODEL-element vector around a supplied mean.
// NUM_PE subtract/square lanes per cycle, start/busy/valid handshake.
module variance_unit #(
    parameter int D_MODEL        = 128,
    parameter int DATA_WIDTH     = 24,
    parameter int NUM_PE         = 8,
    parameter int INTERNAL_WIDTH = 48
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [D_MODEL*DATA_WIDTH-1:0]   data_in_flat,
    input  logic [DATA_WIDTH-1:0]           mean_in,
    input  logic                            start_variance,
    output logic [DATA_WIDTH-1:0]           variance_out,
    output logic                            variance_valid,
    output logic                            busy
);

    localparam int DW     = DATA_WIDTH;
    localparam int IW     = INTERNAL_WIDTH;
    localparam int NCHUNK = D_MODEL / NUM_PE;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SHIFT  = $clog2(D_MODEL);
    localparam int ACC_W  = IW + SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                      state;
    logic [D_MODEL*DW-1:0]       data_q;
    logic [DW-1:0]               mean_q;
    logic [ACC_W-1:0]            acc;
    logic [CW-1:0]               cnt;
    logic [IW-1:0]               sq [NUM_PE];
    logic [ACC_W-1:0]            chunk_sum;
    logic [ACC_W-1:0]            v;
    logic [DW-1:0]               v_sat;

    // Latched vector shifts down one chunk per cycle, so lanes always read the low slice
    for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
        logic [DW-1:0]           x;
        logic signed [DW:0]      diff;
        logic signed [DW-1:0]    d;
        logic signed [2*DW-1:0]  p;

        assign x    = data_q[k*DW +: DW];
        assign diff = $signed({x[DW-1], x}) - $signed({mean_q[DW-1], mean_q});

        always_comb begin
            d = diff[DW-1:0];
            if (diff[DW] != diff[DW-1]) begin
                d = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            end
        end

        assign p     = d * d;
        assign sq[k] = IW'($unsigned(p));
    end

    always_comb begin
        chunk_sum = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            chunk_sum = chunk_sum + ACC_W'(sq[k]);
        end
    end

    assign v     = acc >> SHIFT;
    assign v_sat = (|v[ACC_W-1:DW]) ? {DW{1'b1}} : v[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            data_q         <= '0;
            mean_q         <= '0;
            acc            <= '0;
            cnt            <= '0;
            variance_out   <= '0;
            variance_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            variance_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_variance) begin
                        data_q <= data_in_flat;
                        mean_q <= mean_in;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc    <= acc + chunk_sum;
                    data_q <= data_q >> (NUM_PE*DW);
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(NCHUNK-1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    variance_out   <= v_sat;
                    variance_valid <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_variance_unit.sv
// Bench for variance_unit: directed cases, protocol checks and random
// vectors against a plain-arithmetic variance model.
module tb_variance_unit;

    localparam int D  = 128;
    localparam int DW = 24;
    localparam int PE = 8;
    localparam int IW = 48;
    localparam int LAT = D/PE + 1;

    logic              clk = 0;
    logic              rst;
    logic [D*DW-1:0]   data_in_flat;
    logic [DW-1:0]     mean_in;
    logic              start_variance;
    logic [DW-1:0]     variance_out;
    logic              variance_valid;
    logic              busy;

    logic [DW-1:0]     elems [D];

    int n_cmp = 0;
    int n_bad = 0;

    variance_unit #(
        .D_MODEL(D), .DATA_WIDTH(DW), .NUM_PE(PE), .INTERNAL_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in_flat(data_in_flat),
        .mean_in(mean_in),
        .start_variance(start_variance),
        .variance_out(variance_out),
        .variance_valid(variance_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model(input logic [DW-1:0] m);
        longint sum = 0;
        longint mv = longint'($signed(m));
        longint dv, v;
        for (int i = 0; i < D; i++) begin
            dv = longint'($signed(elems[i])) - mv;
            if (dv > 8388607) dv = 8388607;
            if (dv < -8388608) dv = -8388608;
            sum += dv * dv;
        end
        v = sum / D;
        if (v > 16777215) v = 16777215;
        return v;
    endfunction

    task automatic load();
        for (int i = 0; i < D; i++) data_in_flat[i*DW +: DW] = elems[i];
    endtask

    // Launch one job and wait (bounded) for its valid pulse.
    task automatic run_job(input string tag, input logic [DW-1:0] m);
        int lat = 0;
        bit got = 0;
        longint exp = model(m);
        @(negedge clk);
        load();
        mean_in = m;
        start_variance = 1;
        @(posedge clk);
        #1;
        start_variance = 0;
        data_in_flat = '0;
        mean_in = '0;
        chk({tag, ".busy"}, busy, 1);
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (variance_valid) got = 1;
        end
        chk({tag, ".got"}, got, 1);
        chk({tag, ".lat"}, lat, LAT);
        chk({tag, ".val"}, variance_out, exp);
        chk({tag, ".busy_done"}, busy, 0);
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, variance_valid, 0);
        chk({tag, ".hold"}, variance_out, exp);
    endtask

    initial begin
        int nv;
        int first;
        int second;
        logic [DW-1:0] m;
        rst = 1;
        start_variance = 0;
        data_in_flat = '0;
        mean_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out", variance_out, 0);
        chk("rst.valid", variance_valid, 0);
        chk("rst.busy", busy, 0);
        rst = 0;

        for (int i = 0; i < D; i++) elems[i] = 24'd100;
        run_job("t1_flat", 24'd100);
        for (int i = 0; i < D; i++) elems[i] = (i % 2) ? 24'd101 : 24'd99;
        run_job("t2_alt", 24'd100);
        for (int i = 0; i < D; i++) elems[i] = DW'(i);
        run_job("t3_ramp", 24'd63);
        chk("t3_const", variance_out, 1365);
        for (int i = 0; i < D; i++) elems[i] = 24'hFFFFFB;
        run_job("t4_neg", 24'd3);
        chk("t4_const", variance_out, 64);
        for (int i = 0; i < D; i++) elems[i] = (i % 2) ? 24'h800000 : 24'h7FFFFF;
        run_job("t5_sat", 24'd0);
        chk("t5_const", variance_out, 24'hFFFFFF);

        // Second start mid-job must be ignored
        for (int i = 0; i < D; i++) elems[i] = DW'(3 * i);
        @(negedge clk);
        load();
        mean_in = 24'd190;
        start_variance = 1;
        @(negedge clk);
        start_variance = 0;
        repeat (5) @(negedge clk);
        start_variance = 1;
        @(negedge clk);
        start_variance = 0;
        nv = 0;
        first = 0;
        for (int c = 1; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (variance_valid) begin
                nv++;
                if (first == 0) first = c + 6;
            end
        end
        chk("p_ign.count", nv, 1);
        chk("p_ign.lat", first, LAT);
        chk("p_ign.val", variance_out, model(24'd190));

        // Reset mid-job aborts without a pulse
        for (int i = 0; i < D; i++) elems[i] = DW'(i * 7);
        @(negedge clk);
        load();
        mean_in = 24'd5;
        start_variance = 1;
        @(negedge clk);
        start_variance = 0;
        repeat (6) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("p_rst.busy", busy, 0);
        chk("p_rst.valid", variance_valid, 0);
        chk("p_rst.out", variance_out, 0);
        nv = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (variance_valid) nv++;
        end
        chk("p_rst.novalid", nv, 0);
        run_job("p_rst.fresh", 24'd5);

        // Held start: back-to-back jobs, second begins the edge after DONE
        for (int i = 0; i < D; i++) elems[i] = DW'(i % 11);
        @(negedge clk);
        load();
        mean_in = 24'd4;
        start_variance = 1;
        @(posedge clk);
        nv = 0;
        first = 0;
        second = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (variance_valid) begin
                nv++;
                if (nv == 1) first = c;
                if (nv == 2) second = c;
            end
        end
        start_variance = 0;
        chk("p_hold.first", first, LAT);
        chk("p_hold.second", second, 2 * LAT + 1);
        chk("p_hold.val", variance_out, model(24'd4));
        repeat (LAT + 3) @(posedge clk);

        // Random vectors: mix of narrow and full-range spreads
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < D; i++) begin
                if (t % 3 == 0) elems[i] = DW'($urandom);
                else if (t % 3 == 1) elems[i] = DW'($urandom_range(0, 2000)) - 24'd1000;
                else elems[i] = DW'($urandom_range(0, 65535));
            end
            m = (t % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 4000)) - 24'd2000;
            run_job($sformatf("rnd%0d", t), m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
